// File: rtl/animator_if.sv
// Keyframe-store / frame-buffer bus of the animator: drq handshake, RAM read port,
// result write port and status pulses.
interface animator_if #(
   parameter int unsigned c_addr_w = 10,
   parameter int unsigned c_bpc    = 12,
   parameter int unsigned c_time_w = 9
);
   logic                i_drq;
   logic [1:0]          i_mode;
   logic [c_time_w-1:0] i_target_time;
   logic [c_bpc-1:0]    i_current_data;
   logic [c_bpc-1:0]    i_target_data;
   logic [c_addr_w-1:0] o_raddr;
   logic                o_wen;
   logic [c_addr_w-1:0] o_waddr;
   logic [c_bpc-1:0]    o_wdata;
   logic [c_time_w-1:0] o_time;
   logic                o_busy;
   logic                o_kf_req;
   logic                o_overrun;

   modport master (
      input  i_drq, i_mode, i_target_time, i_current_data, i_target_data,
      output o_raddr, o_wen, o_waddr, o_wdata, o_time, o_busy, o_kf_req, o_overrun
   );

   modport slave (
      output i_drq, i_mode, i_target_time, i_current_data, i_target_data,
      input  o_raddr, o_wen, o_waddr, o_wdata, o_time, o_busy, o_kf_req, o_overrun
   );
endinterface

// File: rtl/animator_seq.sv
// Keyframe animator: per frame request, advances time and interpolates every channel
// from current toward target with a fixed-latency restoring divider.
module animator_seq #(
   parameter int unsigned c_ledboards = 30,
   parameter int unsigned c_channels  = c_ledboards * 32,
   parameter int unsigned c_addr_w    = $clog2(c_channels),
   parameter int unsigned c_bpc       = 12,
   parameter int unsigned c_max_time  = 480,
   parameter int unsigned c_time_w    = $clog2(c_max_time)
) (
   input  logic i_clk,
   input  logic i_rst,
   animator_if.master bus
);

   localparam int unsigned RemW = c_time_w + 1;
   localparam int unsigned PrW  = RemW + 1;
   localparam int unsigned CntW = $clog2(c_bpc + 1);

   typedef enum logic [2:0] {StIdle, StRead, StLoad, StDiv, StWrite, StEnd} state_e;

   state_e              state_q, state_d;
   logic [c_time_w-1:0] time_q, time_d;
   logic [c_addr_w-1:0] addr_q, addr_d;
   logic [c_bpc-1:0]    cur_q, cur_d;
   logic [c_bpc-1:0]    tgt_q, tgt_d;
   logic [1:0]          mode_q, mode_d;
   logic                neg_q, neg_d;
   logic [RemW-1:0]     rem_q, rem_d;
   logic [c_bpc-1:0]    dvd_q, dvd_d;
   logic [RemW-1:0]     pr_q, pr_d;
   logic [c_bpc-1:0]    quo_q, quo_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                wen_q, wen_d;
   logic [c_bpc-1:0]    wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                kf_q, kf_d;
   logic                ovr_q, ovr_d;

   logic [RemW-1:0]  rem_calc;
   logic [c_bpc:0]   diff;
   logic [c_bpc:0]   mag;
   logic [PrW-1:0]   pr_shift;
   logic             quo_bit;
   logic [PrW-1:0]   pr_next;
   logic [c_bpc-1:0] quo_next;
   logic [c_bpc-1:0] result;

   // Remaining frames to the keyframe, wrapping through the end of the time period.
   always_comb begin
      if (RemW'(bus.i_target_time) >= RemW'(time_q)) begin
         rem_calc = RemW'(bus.i_target_time) - RemW'(time_q);
      end else begin
         rem_calc = RemW'(c_max_time) - RemW'(time_q) + RemW'(bus.i_target_time);
      end
      diff = {1'b0, bus.i_target_data} - {1'b0, bus.i_current_data};
      mag  = diff[c_bpc] ? (~diff + 1'b1) : diff;
   end

   always_comb begin
      pr_shift = {pr_q, dvd_q[c_bpc-1]};
      quo_bit  = (pr_shift >= {1'b0, rem_q});
      pr_next  = quo_bit ? (pr_shift - {1'b0, rem_q}) : pr_shift;
      quo_next = {quo_q[c_bpc-2:0], quo_bit};
      unique case (mode_q)
         2'd0: begin
            if (rem_q == '0) begin
               result = tgt_q;
            end else begin
               result = neg_q ? (cur_q - quo_next) : (cur_q + quo_next);
            end
         end
         2'd1:    result = (rem_q == '0) ? tgt_q : cur_q;
         2'd2:    result = tgt_q;
         default: result = cur_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      addr_d  = addr_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      mode_d  = mode_q;
      neg_d   = neg_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      pr_d    = pr_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      wen_d   = 1'b0;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      kf_d    = 1'b0;
      ovr_d   = bus.i_drq && (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (bus.i_drq) begin
               time_d  = (time_q == c_time_w'(c_max_time - 1)) ? '0 : time_q + 1'b1;
               addr_d  = '0;
               busy_d  = 1'b1;
               state_d = StRead;
            end
         end
         StRead: state_d = StLoad;
         StLoad: begin
            cur_d   = bus.i_current_data;
            tgt_d   = bus.i_target_data;
            mode_d  = bus.i_mode;
            neg_d   = diff[c_bpc];
            rem_d   = rem_calc;
            dvd_d   = mag[c_bpc-1:0];
            pr_d    = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = StDiv;
         end
         StDiv: begin
            pr_d  = pr_next[RemW-1:0];
            quo_d = quo_next;
            dvd_d = {dvd_q[c_bpc-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(c_bpc - 1)) begin
               wen_d   = 1'b1;
               wdata_d = result;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (addr_q == c_addr_w'(c_channels - 1)) begin
               kf_d    = (rem_q == '0);
               state_d = StEnd;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = StRead;
            end
         end
         StEnd: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         time_q  <= '0;
         addr_q  <= '0;
         cur_q   <= '0;
         tgt_q   <= '0;
         mode_q  <= '0;
         neg_q   <= 1'b0;
         rem_q   <= '0;
         dvd_q   <= '0;
         pr_q    <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         kf_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
         addr_q  <= addr_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         mode_q  <= mode_d;
         neg_q   <= neg_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         pr_q    <= pr_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         kf_q    <= kf_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.o_raddr   = addr_q;
   assign bus.o_waddr   = addr_q;
   assign bus.o_wen     = wen_q;
   assign bus.o_wdata   = wdata_q;
   assign bus.o_time    = time_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_kf_req  = kf_q;
   assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_animator_seq.sv
// Randomized bench for animator_seq: keyframe RAM model, arithmetic reference model and
// cycle-accurate write/pulse checks on a reduced-size instance.
module tb_animator_seq;

   localparam int unsigned LB   = 1;
   localparam int unsigned CH   = LB * 32;
   localparam int unsigned AW   = $clog2(CH);
   localparam int unsigned BPC  = 12;
   localparam int unsigned MAXT = 24;
   localparam int unsigned TW   = $clog2(MAXT);
   localparam int          PER  = BPC + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   animator_if #(.c_addr_w(AW), .c_bpc(BPC), .c_time_w(TW)) bus ();

   animator_seq #(.c_ledboards(LB), .c_bpc(BPC), .c_max_time(MAXT)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [BPC-1:0] cur_mem  [CH];
   logic [BPC-1:0] tgt_mem  [CH];
   logic [1:0]     mode_mem [CH];
   logic [BPC-1:0] cur_rd, tgt_rd;
   logic [1:0]     mode_rd;

   // Synchronous-read keyframe RAMs: data valid the cycle after the address.
   always @(posedge clk) begin
      cur_rd  <= cur_mem[bus.o_raddr];
      tgt_rd  <= tgt_mem[bus.o_raddr];
      mode_rd <= mode_mem[bus.o_raddr];
   end

   assign bus.i_current_data = cur_rd;
   assign bus.i_target_data  = tgt_rd;
   assign bus.i_mode         = mode_rd;

   int n_chk  = 0;
   int n_fail = 0;
   int m_time = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_val(input int cur, input int tgt, input int mode, input int rem);
      case (mode)
         0:       return (rem == 0) ? tgt : cur + (tgt - cur) / rem;
         1:       return (rem == 0) ? tgt : cur;
         2:       return tgt;
         default: return cur;
      endcase
   endfunction

   task automatic fill(input int cur, input int tgt, input int mode);
      for (int i = 0; i < CH; i++) begin
         cur_mem[i]  = BPC'(cur);
         tgt_mem[i]  = BPC'(tgt);
         mode_mem[i] = 2'(mode);
      end
   endtask

   task automatic fill_rand(input int mlo, input int mhi);
      for (int i = 0; i < CH; i++) begin
         cur_mem[i]  = BPC'($urandom);
         tgt_mem[i]  = BPC'($urandom);
         mode_mem[i] = 2'($urandom_range(mhi, mlo));
      end
   endtask

   // Drq is held high together with reset: reset must win.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_drq = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_drq = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_time = 0;
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_time", bus.o_time, 0);
      chk("rst_wen", bus.o_wen, 0);
      chk("rst_kf", bus.o_kf_req, 0);
      chk("rst_ovr", bus.o_overrun, 0);
      chk("rst_raddr", bus.o_raddr, 0);
   endtask

   task automatic run_frame(input int tt, input bit ovr, input int rst_ch);
      int rem, next_ch, kf_cnt, ov_cnt, wen_cnt, limit, t_frame;
      int exp_d [CH];
      m_time  = (m_time == MAXT - 1) ? 0 : m_time + 1;
      t_frame = m_time;
      rem     = (tt >= m_time) ? tt - m_time : MAXT - m_time + tt;
      for (int i = 0; i < CH; i++) begin
         exp_d[i] = exp_val(int'(cur_mem[i]), int'(tgt_mem[i]), int'(mode_mem[i]), rem);
      end
      bus.i_target_time = TW'(tt);
      @(negedge clk);
      bus.i_drq = 1'b1;
      @(posedge clk);
      #1;
      bus.i_drq = 1'b0;
      chk("start_time", bus.o_time, t_frame);
      chk("start_busy", bus.o_busy, 1);
      next_ch = 0;
      kf_cnt  = 0;
      ov_cnt  = 0;
      limit   = CH * PER + 10;
      for (int c = 1; c <= limit; c++) begin
         if (bus.o_wen) begin
            chk("waddr", bus.o_waddr, next_ch);
            chk("wdata", bus.o_wdata, (next_ch < CH) ? exp_d[next_ch] : -1);
            chk("wen_cycle", c, PER + next_ch * PER);
            next_ch++;
         end
         if (bus.o_kf_req) kf_cnt++;
         if (bus.o_overrun) ov_cnt++;
         if (rst_ch >= 0 && c == 3 + rst_ch * PER + 5) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            m_time = 0;
            chk("abort_wen", bus.o_wen, 0);
            chk("abort_busy", bus.o_busy, 0);
            chk("abort_time", bus.o_time, 0);
            kf_cnt  = 0;
            wen_cnt = 0;
            repeat (40) begin
               @(posedge clk);
               #1;
               kf_cnt  += int'(bus.o_kf_req);
               wen_cnt += int'(bus.o_wen);
            end
            chk("abort_no_kf", kf_cnt, 0);
            chk("abort_no_wen", wen_cnt, 0);
            return;
         end
         if (!bus.o_busy) break;
         bus.i_drq = ovr && (c == 20);
         @(posedge clk);
         #1;
      end
      bus.i_drq = 1'b0;
      chk("end_busy", bus.o_busy, 0);
      chk("wen_count", next_ch, CH);
      chk("kf_count", kf_cnt, (rem == 0) ? 1 : 0);
      chk("ovr_count", ov_cnt, ovr ? 1 : 0);
      chk("end_time", bus.o_time, t_frame);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_drq = 1'b0;
      bus.i_target_time = '0;
      fill(0, 0, 0);
      do_reset();

      // Linear, positive then negative delta (truncation toward zero).
      fill(100, 200, 0);
      run_frame(10, 1'b0, -1);
      do_reset();
      fill(200, 100, 0);
      run_frame(10, 1'b0, -1);

      // Arrival in linear/hold, then hold with time remaining.
      fill_rand(0, 1);
      run_frame((m_time + 1) % MAXT, 1'b0, -1);
      fill_rand(1, 1);
      run_frame((m_time + 1 + 5) % MAXT, 1'b0, -1);

      // Overrun during a snap/freeze frame.
      fill_rand(2, 3);
      run_frame($urandom_range(MAXT - 1, 0), 1'b1, -1);

      // Walk time up to the wrap point, then interpolate across it.
      for (int i = 0; i < MAXT && m_time != MAXT - 3; i++) begin
         fill_rand(0, 3);
         run_frame($urandom_range(MAXT - 1, 0), 1'b0, -1);
      end
      fill(0, 4095, 0);
      run_frame(2, 1'b0, -1);
      fill_rand(0, 3);
      run_frame($urandom_range(MAXT - 1, 0), 1'b0, -1);
      run_frame($urandom_range(MAXT - 1, 0), 1'b0, -1);
      chk("wrap_time", bus.o_time, 0);

      // Abort mid-divide on channel 7, then restart from channel 0.
      fill_rand(0, 3);
      run_frame($urandom_range(MAXT - 1, 0), 1'b0, 7);
      run_frame($urandom_range(MAXT - 1, 0), 1'b0, -1);
      chk("restart_time", bus.o_time, 1);

      for (int i = 0; i < 15; i++) begin
         fill_rand(0, 3);
         run_frame($urandom_range(MAXT - 1, 0), ($urandom_range(3, 0) == 0), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
